matmul_engine: RTL

Parametrised, handshaked successor to the fixed 8-bit matrix multiplier. It accepts run-time dimensions up to MAXD×MAXD and streams in both operand matrices over a valid/ready port. It computes C = A×B with one multiply-accumulate per cycle and streams C out row-major over a second valid/ready port. It sits between the host load path and the result consumer, replacing the start/program_val/result_read protocol.

---
 rtl/matmul_engine_if.sv | 59 +++++
 rtl/matmul_engine.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_engine_if.sv
// ============================================================================
// Module      : matmul_engine_if
// Description : Handshake bundle for matmul_engine: dimension request port,
//               operand stream port, result stream port and status flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface matmul_engine_if #(
  parameter int DW   = 8,
  parameter int MAXD = 8,
  parameter int OW   = 16
);
  localparam int DIMW = $clog2(MAXD + 1);
  localparam int IW   = $clog2(MAXD);

  logic            cfg_valid;
  logic            cfg_ready;
  logic [DIMW-1:0] cfg_m;
  logic [DIMW-1:0] cfg_k;
  logic [DIMW-1:0] cfg_k2;
  logic [DIMW-1:0] cfg_n;

  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;

  logic            out_valid;
  logic            out_ready;
  logic [OW-1:0]   out_data;
  logic [IW-1:0]   out_row;
  logic [IW-1:0]   out_col;
  logic            out_last;

  logic            busy;
  logic            err;

  // Host / load path side
  modport master (
    output cfg_valid, cfg_m, cfg_k, cfg_k2, cfg_n,
    output in_valid, in_data,
    output out_ready,
    input  cfg_ready, in_ready,
    input  out_valid, out_data, out_row, out_col, out_last,
    input  busy, err
  );

  // Engine side
  modport slave (
    input  cfg_valid, cfg_m, cfg_k, cfg_k2, cfg_n,
    input  in_valid, in_data,
    input  out_ready,
    output cfg_ready, in_ready,
    output out_valid, out_data, out_row, out_col, out_last,
    output busy, err
  );
endinterface

`default_nettype wire

// File: rtl/matmul_engine.sv
// ============================================================================
// Module      : matmul_engine
// Description : Run-time sized unsigned matrix multiplier C = A x B.
//               Operands stream in over a valid/ready port (A then B, both
//               row-major), one MAC per cycle computes C, and C streams out
//               row-major over a second valid/ready port.
//               Optional macro MATMUL_SAT_EN: clamp results to 2^OW-1
//               instead of truncating to the low OW bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module matmul_engine #(
  parameter int DW   = 8,
  parameter int MAXD = 8,
  parameter int OW   = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  matmul_engine_if.slave bus
);
  localparam int DIMW = $clog2(MAXD + 1);
  localparam int IW   = $clog2(MAXD);
  localparam int AW   = 2 * DW + $clog2(MAXD);

  localparam logic [DIMW-1:0] MAXD_D  = DIMW'(MAXD);
  localparam logic [AW-1:0]   OUT_MAX = AW'({OW{1'b1}});

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_A  = 3'd1,
    S_LOAD_B  = 3'd2,
    S_COMPUTE = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  // Latched dimensions (k2 only matters for the validity check)
  logic [DIMW-1:0] r_m;
  logic [DIMW-1:0] r_k;
  logic [DIMW-1:0] r_n;
  logic            r_err;

  // Operand load indices
  logic [IW-1:0]   r_ld_row;
  logic [IW-1:0]   r_ld_col;

  // Compute indices: C element (i,j), inner product step p
  logic [IW-1:0]   r_i;
  logic [IW-1:0]   r_j;
  logic [IW-1:0]   r_p;
  logic            r_store;
  logic [AW-1:0]   r_acc;

  // Drain indices, also the visible out_row/out_col
  logic [IW-1:0]   r_out_row;
  logic [IW-1:0]   r_out_col;

  // Matrix storage, never reset
  logic [DW-1:0]   r_a [MAXD][MAXD];
  logic [DW-1:0]   r_b [MAXD][MAXD];
  logic [OW-1:0]   r_c [MAXD][MAXD];

  logic            w_cfg_fire;
  logic            w_cfg_bad;
  logic            w_in_fire;
  logic            w_out_fire;
  logic [IW-1:0]   w_m_last;
  logic [IW-1:0]   w_k_last;
  logic [IW-1:0]   w_n_last;
  logic            w_ld_col_last;
  logic            w_ld_row_last;
  logic            w_p_last;
  logic            w_j_last;
  logic            w_i_last;
  logic            w_out_last;
  logic [AW-1:0]   w_prod;
  logic [AW-1:0]   w_acc_next;
  logic [OW-1:0]   w_narrow;

  logic            w_cfg_ready;
  logic            w_in_ready;
  logic            w_out_valid;
  logic            w_busy;

  // Handshakes are decoded straight from state so they never loop back
  // through the FSM output logic.
  assign w_cfg_fire = bus.cfg_valid & (r_state == S_IDLE);
  assign w_in_fire  = bus.in_valid & ((r_state == S_LOAD_A) | (r_state == S_LOAD_B));
  assign w_out_fire = bus.out_ready & (r_state == S_DRAIN);

  assign w_cfg_bad = (bus.cfg_k != bus.cfg_k2) |
                     (bus.cfg_m == '0) | (bus.cfg_k == '0) |
                     (bus.cfg_k2 == '0) | (bus.cfg_n == '0) |
                     (bus.cfg_m > MAXD_D) | (bus.cfg_k > MAXD_D) |
                     (bus.cfg_k2 > MAXD_D) | (bus.cfg_n > MAXD_D);

  // Dimensions are validated to 1..MAXD, so dim-1 always fits in IW bits
  assign w_m_last = IW'(r_m - 1'b1);
  assign w_k_last = IW'(r_k - 1'b1);
  assign w_n_last = IW'(r_n - 1'b1);

  // A is m x k, B is k x n
  assign w_ld_col_last = (r_ld_col == ((r_state == S_LOAD_A) ? w_k_last : w_n_last));
  assign w_ld_row_last = (r_ld_row == ((r_state == S_LOAD_A) ? w_m_last : w_k_last));

  assign w_p_last   = (r_p == w_k_last);
  assign w_j_last   = (r_j == w_n_last);
  assign w_i_last   = (r_i == w_m_last);
  assign w_out_last = (r_state == S_DRAIN) & (r_out_row == w_m_last) & (r_out_col == w_n_last);

  // Accumulator restarts from zero on the first step of each element
  assign w_prod     = AW'(r_a[r_i][r_p]) * AW'(r_b[r_p][r_j]);
  assign w_acc_next = ((r_p == '0) ? '0 : r_acc) + w_prod;

`ifdef MATMUL_SAT_EN
  assign w_narrow = (r_acc > OUT_MAX) ? {OW{1'b1}} : r_acc[OW-1:0];
`else
  assign w_narrow = r_acc[OW-1:0];
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and handshake-ready decode
  always_comb begin
    w_next      = r_state;
    w_cfg_ready = 1'b0;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_cfg_ready = 1'b1;
        w_busy      = 1'b0;
        if (w_cfg_fire && !w_cfg_bad) w_next = S_LOAD_A;
      end
      S_LOAD_A: begin
        w_in_ready = 1'b1;
        if (w_in_fire && w_ld_col_last && w_ld_row_last) w_next = S_LOAD_B;
      end
      S_LOAD_B: begin
        w_in_ready = 1'b1;
        if (w_in_fire && w_ld_col_last && w_ld_row_last) w_next = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (r_store && w_j_last && w_i_last) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        w_out_valid = 1'b1;
        if (w_out_fire && w_out_last) w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Control registers: dimensions, error flag, load/compute/drain indices
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_m       <= '0;
      r_k       <= '0;
      r_n       <= '0;
      r_err     <= 1'b0;
      r_ld_row  <= '0;
      r_ld_col  <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_p       <= '0;
      r_store   <= 1'b0;
      r_acc     <= '0;
      r_out_row <= '0;
      r_out_col <= '0;
    end else begin
      if (w_cfg_fire) begin
        r_m   <= bus.cfg_m;
        r_k   <= bus.cfg_k;
        r_n   <= bus.cfg_n;
        r_err <= w_cfg_bad;
      end

      if (w_in_fire) begin
        if (w_ld_col_last) begin
          r_ld_col <= '0;
          r_ld_row <= w_ld_row_last ? '0 : r_ld_row + 1'b1;
        end else begin
          r_ld_col <= r_ld_col + 1'b1;
        end
      end

      if (r_state == S_COMPUTE) begin
        if (!r_store) begin
          r_acc <= w_acc_next;
          if (w_p_last) begin
            r_p     <= '0;
            r_store <= 1'b1;
          end else begin
            r_p <= r_p + 1'b1;
          end
        end else begin
          r_store <= 1'b0;
          if (w_j_last) begin
            r_j <= '0;
            r_i <= w_i_last ? '0 : r_i + 1'b1;
          end else begin
            r_j <= r_j + 1'b1;
          end
        end
      end

      if (w_out_fire) begin
        if (w_out_last) begin
          r_out_row <= '0;
          r_out_col <= '0;
        end else if (r_out_col == w_n_last) begin
          r_out_col <= '0;
          r_out_row <= r_out_row + 1'b1;
        end else begin
          r_out_col <= r_out_col + 1'b1;
        end
      end
    end
  end

  // Matrix storage writes: operand loads and result stores
  always_ff @(posedge clk) begin
    if (w_in_fire && (r_state == S_LOAD_A)) r_a[r_ld_row][r_ld_col] <= bus.in_data;
    if (w_in_fire && (r_state == S_LOAD_B)) r_b[r_ld_row][r_ld_col] <= bus.in_data;
    if ((r_state == S_COMPUTE) && r_store)  r_c[r_i][r_j] <= w_narrow;
  end

  assign bus.cfg_ready = w_cfg_ready;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_valid ? r_c[r_out_row][r_out_col] : '0;
  assign bus.out_row   = r_out_row;
  assign bus.out_col   = r_out_col;
  assign bus.out_last  = w_out_last;
  assign bus.busy      = w_busy;
  assign bus.err       = r_err;

endmodule

`default_nettype wire
